// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the register-file writeback controller.
//   DATA_W    : register data width
//   ADDR_W    : register address width
//   NUM_REGS  : number of architectural registers (width of the pending vector)
//   req_idx_e : index of each writeback requester in the arbiter req/grant vectors
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_idx_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter with a combinational grant.
//   clk   : clock
//   rst   : synchronous active-high reset; forces grant to 0 and favours REQ_ALU
//   req   : request vector, indexed by req_idx_e
//   grant : one-hot (or zero) grant vector, same indexing as req
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // Requester favoured at the next contended cycle.
    req_idx_e ptr;

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (req == 2'b11) begin
                grant = (ptr == REQ_ALU) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    // Uncontended grants leave the pointer alone, so a lone requester
    // cannot steal the other side's turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ_ALU;
        end else if (req == 2'b11) begin
            ptr <= (ptr == REQ_ALU) ? REQ_LD : REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Arbitrates ALU and load writebacks into a single register-file write port
// and keeps a pending-writeback scoreboard for hazard detection.
//   clk, rst                       : clock, synchronous active-high reset
//   alu_valid/alu_ready/rd/data    : ALU writeback request channel
//   ld_valid/ld_ready/rd/data      : load writeback request channel
//   iss_valid, iss_rd              : instruction issue claiming a destination
//   chk_rs1, chk_rs2, hazard       : source-operand readiness check
//   rf_we, rf_rd_addr, rf_rd_data  : registered register-file write port
//   pending                        : per-register awaiting-writeback bits
//   err                            : sticky write-after-write issue error
module regfile_wb_ctrl #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_W-1:0]             alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [ADDR_W-1:0]             ld_rd,
    input  logic [DATA_W-1:0]             ld_data,
    input  logic                          iss_valid,
    input  logic [ADDR_W-1:0]             iss_rd,
    input  logic [ADDR_W-1:0]             chk_rs1,
    input  logic [ADDR_W-1:0]             chk_rs2,
    output logic                          hazard,
    output logic                          rf_we,
    output logic [ADDR_W-1:0]             rf_rd_addr,
    output logic [DATA_W-1:0]             rf_rd_data,
    output logic [regfile_pkg::NUM_REGS-1:0] pending,
    output logic                          err
);

    import regfile_pkg::*;

    logic [1:0]          grant;
    logic                acc_p0;
    logic                wr_p0;
    logic [ADDR_W-1:0]   rd_p0;
    logic [DATA_W-1:0]   data_p0;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] pending_nxt;
    logic                waw;
    logic                inflight_hit;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({ld_valid, alu_valid}),
        .grant (grant)
    );

    assign alu_ready = grant[REQ_ALU];
    assign ld_ready  = grant[REQ_LD];

    // Stage p0: accepted request selected by the grant.
    assign acc_p0  = |grant;
    assign rd_p0   = grant[REQ_LD] ? ld_rd   : alu_rd;
    assign data_p0 = grant[REQ_LD] ? ld_data : alu_data;
    // Writes to x0 are acknowledged but never reach the register file.
    assign wr_p0   = acc_p0 && (rd_p0 != '0);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (wr_p0) begin
            clr_mask[rd_p0] = 1'b1;
        end
        if (iss_valid && (iss_rd != '0)) begin
            set_mask[iss_rd] = 1'b1;
        end
        // Set is applied after clear so a same-cycle issue keeps the bit.
        pending_nxt    = (pending & ~clr_mask) | set_mask;
        pending_nxt[0] = 1'b0;
    end

    // Re-issue of a register still awaiting writeback, unless that
    // writeback lands in this very cycle.
    assign waw = (|(set_mask & pending & ~clr_mask));

    // Stage p1: registered write port and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
            pending    <= '0;
            err        <= 1'b0;
        end else begin
            rf_we   <= wr_p0;
            pending <= pending_nxt;
            if (wr_p0) begin
                rf_rd_addr <= rd_p0;
                rf_rd_data <= data_p0;
            end
            if (waw) begin
                err <= 1'b1;
            end
        end
    end

    // The scoreboard bit clears on the same edge as rf_we rises, so the
    // write still travelling to the register file must also block readers.
    assign inflight_hit = rf_we && (rf_rd_addr != '0) &&
                          ((rf_rd_addr == chk_rs1) || (rf_rd_addr == chk_rs2));
    assign hazard = pending[chk_rs1] | pending[chk_rs2] | inflight_hit;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl
// Scoreboard bench for regfile_wb_ctrl: the stimulus process predicts every
// observable output for the cycle and queues it; a monitor on the falling
// edge pops and compares.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid, iss_valid;
    logic        alu_ready, ld_ready;
    logic [4:0]  alu_rd, ld_rd, iss_rd, chk_rs1, chk_rs2;
    logic [31:0] alu_data, ld_data;
    logic        hazard, rf_we, err;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [31:0] pending;

    regfile_wb_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .hazard     (hazard),
        .rf_we      (rf_we),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .pending    (pending),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ar;
        logic        lr;
        logic        hz;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pend;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: what the DUT outputs should show after the last edge.
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_pend [32];
    logic        m_err;
    bit          m_ld_turn;   // 1 when the load side wins the next contention

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        m_we = 0; m_addr = 0; m_data = 0; m_err = 0; m_ld_turn = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    // Apply inputs, predict outputs for this cycle, advance the model, then
    // move to just after the next rising edge.
    task automatic step(input logic r,
                        input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] s1, input logic [4:0] s2);
        exp_t e;
        bit   g_alu, g_ld;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        bit   wr;
        rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_valid = lv; ld_rd = lrd; ld_data = ldat;
        iss_valid = iv; iss_rd = ird; chk_rs1 = s1; chk_rs2 = s2;

        g_alu = 0; g_ld = 0;
        if (!r) begin
            if (av && lv) begin
                g_ld  = m_ld_turn;
                g_alu = !m_ld_turn;
            end else begin
                g_alu = av;
                g_ld  = lv;
            end
        end
        e.ar   = g_alu;
        e.lr   = g_ld;
        e.hz   = m_pend[s1] || m_pend[s2] ||
                 (m_we && m_addr != 0 && (m_addr == s1 || m_addr == s2));
        e.we   = m_we;
        e.addr = m_addr;
        e.data = m_data;
        e.pend = pend_vec();
        e.err  = m_err;
        exp_q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            if (av && lv) m_ld_turn = !m_ld_turn;
            wrd  = g_ld ? lrd  : ard;
            wdat = g_ld ? ldat : adat;
            wr   = (g_alu || g_ld) && wrd != 0;
            if (iv && ird != 0 && m_pend[ird] && !(wr && wrd == ird)) m_err = 1;
            if (wr) m_pend[wrd] = 0;
            if (iv && ird != 0) m_pend[ird] = 1;
            m_we = wr;
            if (wr) begin
                m_addr = wrd;
                m_data = wdat;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, s1, s2);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: one predicted response per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("alu_ready",  32'(alu_ready),  32'(e.ar));
            chk("ld_ready",   32'(ld_ready),   32'(e.lr));
            chk("hazard",     32'(hazard),     32'(e.hz));
            chk("rf_we",      32'(rf_we),      32'(e.we));
            chk("rf_rd_addr", 32'(rf_rd_addr), 32'(e.addr));
            chk("rf_rd_data", rf_rd_data,      e.data);
            chk("pending",    pending,         e.pend);
            chk("err",        32'(err),        32'(e.err));
        end
    end

    initial begin
        model_reset();
        rst = 1; alu_valid = 0; ld_valid = 0; iss_valid = 0;
        alu_rd = 0; ld_rd = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
        alu_data = 0; ld_data = 0;
        @(posedge clk);
        #1;
        // Reset state, with a request held to confirm ready stays low.
        step(1, 1, 4, 32'h1111_1111, 1, 6, 32'h2222_2222, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single ALU write.
        step(0, 1, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 1, 0);
        idle(1, 0);
        idle(0, 0);

        // Contention: ALU, LD, ALU, LD.
        for (int i = 0; i < 4; i++)
            step(0, 1, 2, 32'h8765_4321, 1, 3, 32'hCAFE_F00D, 0, 0, 2, 3);
        idle(2, 3);

        // x0 write from the load side.
        step(0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        idle(0, 0);

        // Scoreboard: issue 5, check, writeback, in-flight hazard, clear.
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
        idle(5, 0);
        idle(0, 5);
        step(0, 1, 5, 32'h0505_0505, 0, 0, 0, 0, 0, 5, 0);
        idle(5, 0);
        idle(5, 0);

        // Same-cycle issue and writeback on 7, then a second issue to 7.
        step(0, 1, 7, 32'h0707_0707, 0, 0, 0, 1, 7, 7, 0);
        idle(7, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(7, 0);

        // Write to a never-issued register.
        step(0, 0, 0, 0, 1, 9, 32'h0909_0909, 0, 0, 9, 0);
        idle(9, 0);

        // Reset against in-flight writes.
        step(0, 1, 10, 32'hAAAA_0000, 0, 0, 0, 1, 11, 0, 0);
        step(1, 1, 12, 32'hBBBB_0000, 1, 13, 32'hCCCC_0000, 1, 14, 10, 12);
        idle(10, 12);
        idle(10, 12);

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(0, 0);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
